s820_bist_ctrl: RTL and testbench
=================================

// Module: s820_bist_ctrl
// PURPOSE
//  Self-test driver/checker for the s820 sequential benchmark. Drives the circuit's 18 primary
//  inputs from an LFSR, compacts its 19 primary outputs in a MISR and compares the final
//  signature with a golden value. Sits beside the s820 instance as its stimulus/response end.
//  Uses the s820 G18 input (bit CLR_BIT) to clear the circuit's 5 flops before the run.
// PARAMETERS
//  N_IN        18          width of DUT_PI (order G0..G16,G18)
//  N_OUT       19          width of DUT_PO (output order of s820 port list)
//  PAT_COUNT   1024        patterns applied in RUN (1..65535)
//  INIT_CYC    2           cycles G18 is held high in INIT (>=1)
//  CLR_BIT     17          DUT_PI index of G18
//  LFSR_SEED   18'h00001   LFSR reset value; 0 is illegal, replaced by 1
//  MISR_SEED   19'h00000   MISR reset value
//  EXP_SIG     19'h00000   golden signature; set per netlist variant
// PORTS
//  CK          in   1      clock, rising edge
//  RST         in   1      synchronous, active-high reset
//  START       in   1      pulse: begin test (honoured in IDLE or DONE only)
//  DUT_PI      out  N_IN   registered stimulus to s820 inputs
//  DUT_PO      in   N_OUT  s820 outputs (combinational from DUT_PI and flop state)
//  BUSY        out  1      high in INIT, RUN, CMP
//  DONE        out  1      high in DONE state; held until START or RST
//  PASS        out  1      valid when DONE: SIGNATURE == EXP_SIG
//  SIGNATURE   out  N_OUT  current MISR contents
//  PAT_IDX     out  16     patterns applied so far in RUN
// BEHAVIOUR
//  Reset: state=IDLE, DUT_PI=0, BUSY=0, DONE=0, PASS=0, LFSR=LFSR_SEED, MISR=MISR_SEED, PAT_IDX=0.
//  FSM: IDLE -START-> INIT; INIT -(INIT_CYC cycles)-> RUN; RUN -(PAT_IDX==PAT_COUNT-1 at edge)-> CMP;
//       CMP -1 cycle-> DONE; DONE -START-> INIT. START in INIT/RUN/CMP ignored.
//  Entering INIT (from IDLE or DONE): LFSR<=seed, MISR<=MISR_SEED, PAT_IDX<=0, DONE<=0, PASS<=0.
//  INIT: DUT_PI = only bit CLR_BIT set; MISR and LFSR frozen.
//  RUN: DUT_PI = LFSR state with bit CLR_BIT forced 0. Pattern k is on DUT_PI during RUN cycle k;
//       at the closing edge MISR absorbs DUT_PO, LFSR steps, PAT_IDX increments. Exactly
//       PAT_COUNT patterns compacted.
//  LFSR: Fibonacci, x^18+x^11+1, shift toward MSB, feedback into bit 0 = q[17]^q[10].
//  MISR: x^19+x^5+x^2+x+1; next = {m[17:0],0} ^ (m[18] ? poly_taps : 0) ^ DUT_PO.
//  CMP: DUT_PI=0; PASS<=(MISR==EXP_SIG). DONE: DUT_PI=0, SIGNATURE and PAT_IDX held.
//  RST at any state (incl. mid-RUN) aborts to reset values next edge; no partial result kept.
//  PAT_IDX is 16 bits; never wraps since PAT_COUNT<=65535.
// STRUCTURE
//  Package s820_bist_pkg: N_IN/N_OUT, LFSR/MISR tap constants, state enum
//  {IDLE,INIT,RUN,CMP,DONE}.
//  One sub-module: bist_shreg (generic width/tap shift register, MODE = LFSR or MISR,
//  enable and load ports); instantiated twice. FSM and counters stay in top.
// TESTING
//  1 Reset: RST high 2 cycles -> DUT_PI=0, BUSY=0, DONE=0, SIGNATURE=0, PAT_IDX=0.
//  2 PAT_COUNT=4, DUT_PO tied 0 -> DUT_PI in RUN = 0x00001,0x00002,0x00004,0x00008; SIGNATURE=0,
//    DONE after INIT_CYC+4+1 cycles from START.
//  3 PAT_COUNT=1, DUT_PO=19'h00001, MISR_SEED=0 -> SIGNATURE=19'h00001; PASS=1 iff EXP_SIG=19'h00001.
//  4 Real s820 attached, EXP_SIG from golden run -> PASS=1; s820 variant with dead flop -> PASS=0.
//  5 START pulsed during RUN -> ignored, PAT_IDX continues; RST at PAT_IDX=10 -> IDLE, PAT_IDX=0.
//  6 LFSR_SEED=0 -> first RUN pattern 0x00001; G18 bit high for exactly INIT_CYC cycles, 0 in RUN.

Source files
------------

// File: rtl/s820_bist_pkg.sv
// rtl/s820_bist_pkg.sv - shared widths, polynomial taps and state types for the s820 BIST controller
package s820_bist_pkg;

  localparam int N_IN  = 18;
  localparam int N_OUT = 19;

  // Stimulus polynomial x^18+x^11+1: feedback taps q[17] and q[10]
  localparam logic [N_IN-1:0]  LFSR_TAPS = 18'h20400;
  // Compactor polynomial x^19+x^5+x^2+x+1: the MSB folds back into bits 5, 2, 1 and 0
  localparam logic [N_OUT-1:0] MISR_TAPS = 19'h00027;

  typedef enum logic [2:0] {IDLE, INIT, RUN, CMP, DONE} bist_state_e;
  typedef enum logic {SHREG_LFSR, SHREG_MISR} shreg_mode_e;

  // An all-zero LFSR never leaves zero, so that seed is mapped to 1
  function automatic logic [N_IN-1:0] fix_seed(input logic [N_IN-1:0] s);
    return (s == '0) ? N_IN'(1) : s;
  endfunction

endpackage

// File: rtl/s820_bist_ctrl_if.sv
// rtl/s820_bist_ctrl_if.sv - control, status and s820 pin bundle between the BIST controller and its host
interface s820_bist_ctrl_if;
  import s820_bist_pkg::*;

  logic             start;
  logic [N_IN-1:0]  dut_pi;
  logic [N_OUT-1:0] dut_po;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_OUT-1:0] signature;
  logic [15:0]      pat_idx;

  modport master (
    output start, dut_po,
    input  dut_pi, busy, done, pass, signature, pat_idx
  );

  modport slave (
    input  start, dut_po,
    output dut_pi, busy, done, pass, signature, pat_idx
  );

endinterface

// File: rtl/bist_shreg.sv
// rtl/bist_shreg.sv - seedable shift register acting as a Fibonacci LFSR or a MISR
module bist_shreg
  import s820_bist_pkg::*;
#(
  parameter int          W    = 18,
  parameter logic [W-1:0] TAPS = '0,
  parameter logic [W-1:0] SEED = '0,
  parameter shreg_mode_e  MODE = SHREG_LFSR
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] nxt;

  // din is folded in for both modes; an LFSR user simply ties it to zero
  always_comb begin
    nxt = {q[W-2:0], 1'b0} ^ din;
    if (MODE == SHREG_LFSR) begin
      nxt[0] = nxt[0] ^ (^(q & TAPS));
    end else if (q[W-1]) begin
      nxt = nxt ^ TAPS;
    end
  end

  always_ff @(posedge ck) begin
    if (rst || load) begin
      q <= SEED;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/s820_bist_ctrl.sv
// rtl/s820_bist_ctrl.sv - s820 self-test: clears flops via G18, drives LFSR patterns, compacts outputs, checks signature
module s820_bist_ctrl
  import s820_bist_pkg::*;
#(
  parameter int unsigned       PAT_COUNT = 1024,
  parameter int unsigned       INIT_CYC  = 2,
  parameter int unsigned       CLR_BIT   = 17,
  parameter logic [N_IN-1:0]   LFSR_SEED = 18'h00001,
  parameter logic [N_OUT-1:0]  MISR_SEED = 19'h00000,
  parameter logic [N_OUT-1:0]  EXP_SIG   = 19'h00000
) (
  input logic              ck,
  input logic              rst,
  s820_bist_ctrl_if.slave  bus
);

  localparam logic [N_IN-1:0] SEED_EFF  = fix_seed(LFSR_SEED);
  localparam logic [N_IN-1:0] CLR_MASK  = N_IN'(1) << CLR_BIT;
  localparam logic [15:0]     LAST_PAT  = 16'(PAT_COUNT - 1);
  localparam logic [15:0]     LAST_INIT = 16'(INIT_CYC - 1);

  bist_state_e      state;
  logic [15:0]      init_cnt;
  logic [15:0]      pat_idx;
  logic [N_IN-1:0]  dut_pi;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN-1:0]  lfsr_q;
  logic [N_OUT-1:0] misr_q;
  logic             accept;
  logic             lfsr_en;
  logic             misr_en;

  assign accept  = bus.start && (state == IDLE || state == DONE);
  // The LFSR runs one step ahead of the pins so dut_pi can be loaded straight from lfsr_q
  assign lfsr_en = (state == RUN) || (state == INIT && init_cnt == LAST_INIT);
  assign misr_en = (state == RUN);

  bist_shreg #(
    .W    (N_IN),
    .TAPS (LFSR_TAPS),
    .SEED (SEED_EFF),
    .MODE (SHREG_LFSR)
  ) u_lfsr (
    .ck   (ck),
    .rst  (rst),
    .load (accept),
    .en   (lfsr_en),
    .din  ('0),
    .q    (lfsr_q)
  );

  bist_shreg #(
    .W    (N_OUT),
    .TAPS (MISR_TAPS),
    .SEED (MISR_SEED),
    .MODE (SHREG_MISR)
  ) u_misr (
    .ck   (ck),
    .rst  (rst),
    .load (accept),
    .en   (misr_en),
    .din  (bus.dut_po),
    .q    (misr_q)
  );

  always_ff @(posedge ck) begin
    if (rst) begin
      state    <= IDLE;
      init_cnt <= '0;
      pat_idx  <= '0;
      dut_pi   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= INIT;
            init_cnt <= '0;
            pat_idx  <= '0;
            dut_pi   <= CLR_MASK;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
          end
        end
        INIT: begin
          if (init_cnt == LAST_INIT) begin
            state  <= RUN;
            dut_pi <= lfsr_q & ~CLR_MASK;
          end else begin
            init_cnt <= init_cnt + 16'd1;
          end
        end
        RUN: begin
          pat_idx <= pat_idx + 16'd1;
          if (pat_idx == LAST_PAT) begin
            state  <= CMP;
            dut_pi <= '0;
          end else begin
            dut_pi <= lfsr_q & ~CLR_MASK;
          end
        end
        CMP: begin
          state <= DONE;
          pass  <= (misr_q == EXP_SIG);
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_pi    = dut_pi;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.signature = misr_q;
  assign bus.pat_idx   = pat_idx;

endmodule

// File: tb/tb_s820_bist_ctrl.sv
// tb/tb_s820_bist_ctrl.sv - bench for s820_bist_ctrl: timeline model with random aborts plus directed literal checks
`timescale 1ns/1ps
module tb_s820_bist_ctrl;

  localparam int          AP    = 20;
  localparam int          AIC   = 3;
  localparam logic [17:0] ASEED = 18'h2A5F3;
  localparam logic [17:0] CLRM  = 18'h20000;
  localparam logic [18:0] AMS   = 19'h01234;
  localparam logic [18:0] AEXP  = 19'h00000;

  logic ck = 1'b0;
  logic rst_a;
  logic rst_b;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  always #5 ck = ~ck;

  s820_bist_ctrl_if a_if ();
  s820_bist_ctrl_if b_if ();
  s820_bist_ctrl_if c_if ();
  s820_bist_ctrl_if d_if ();

  s820_bist_ctrl #(.PAT_COUNT(AP), .INIT_CYC(AIC), .CLR_BIT(17), .LFSR_SEED(ASEED),
                   .MISR_SEED(AMS), .EXP_SIG(AEXP))
    dut_a (.ck(ck), .rst(rst_a), .bus(a_if.slave));
  s820_bist_ctrl #(.PAT_COUNT(4), .INIT_CYC(2), .CLR_BIT(17), .LFSR_SEED(18'h00001),
                   .MISR_SEED(19'h00000), .EXP_SIG(19'h00000))
    dut_b (.ck(ck), .rst(rst_b), .bus(b_if.slave));
  s820_bist_ctrl #(.PAT_COUNT(1), .INIT_CYC(2), .CLR_BIT(17), .LFSR_SEED(18'h00000),
                   .MISR_SEED(19'h00000), .EXP_SIG(19'h00001))
    dut_c (.ck(ck), .rst(rst_b), .bus(c_if.slave));
  s820_bist_ctrl #(.PAT_COUNT(1), .INIT_CYC(2), .CLR_BIT(17), .LFSR_SEED(18'h00001),
                   .MISR_SEED(19'h00000), .EXP_SIG(19'h00002))
    dut_d (.ck(ck), .rst(rst_b), .bus(d_if.slave));

  function automatic logic [17:0] lfsr_step(input logic [17:0] q);
    return {q[16:0], q[17] ^ q[10]};
  endfunction

  function automatic logic [18:0] misr_step(input logic [18:0] m, input logic [18:0] po);
    return {m[17:0], 1'b0} ^ (m[18] ? 19'h00027 : 19'h00000) ^ po;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model of dut_a as a timeline: m_t counts edges since the accepted START
  bit          m_started;
  int          m_t;
  logic [17:0] m_lfsr;
  logic [18:0] m_sig;

  always @(posedge ck) begin
    if (rst_a) begin
      m_started <= 1'b0;
      m_t       <= 0;
      m_lfsr    <= ASEED;
      m_sig     <= AMS;
    end else if (a_if.start && (!m_started || m_t > AIC + AP)) begin
      m_started <= 1'b1;
      m_t       <= 0;
      m_lfsr    <= ASEED;
      m_sig     <= AMS;
    end else if (m_started && m_t <= AIC + AP) begin
      m_t <= m_t + 1;
      if (m_t >= AIC && m_t < AIC + AP) begin
        m_sig  <= misr_step(m_sig, a_if.dut_po);
        m_lfsr <= lfsr_step(m_lfsr);
      end
    end
  end

  // 0 idle, 1 clearing, 2 applying patterns, 3 comparing, 4 finished
  function automatic int ph();
    if (!m_started) return 0;
    if (m_t < AIC) return 1;
    if (m_t < AIC + AP) return 2;
    if (m_t == AIC + AP) return 3;
    return 4;
  endfunction

  function automatic logic [31:0] exp_pi();
    case (ph())
      1: return 32'(CLRM);
      2: return 32'(m_lfsr & ~CLRM);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_idx();
    case (ph())
      2: return 32'(m_t - AIC);
      3, 4: return 32'(AP);
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge ck) begin
    if (chk_en) begin
      chk("a_dut_pi", 32'(a_if.dut_pi), exp_pi());
      chk("a_pat_idx", 32'(a_if.pat_idx), exp_idx());
      chk("a_signature", 32'(a_if.signature), 32'(m_sig));
      chk("a_busy", 32'(a_if.busy), 32'(ph() >= 1 && ph() <= 3));
      chk("a_done", 32'(a_if.done), 32'(ph() == 4));
      chk("a_pass", 32'(a_if.pass), 32'(ph() == 4 && m_sig == AEXP));
    end
  end

  int done_at;
  int g18_hi;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.start = 1'b0; a_if.dut_po = '0;
    b_if.start = 1'b0; b_if.dut_po = '0;
    c_if.start = 1'b0; c_if.dut_po = 19'h00001;
    d_if.start = 1'b0; d_if.dut_po = 19'h00001;
    repeat (2) @(posedge ck);
    @(negedge ck);

    chk("rst_pi", 32'(b_if.dut_pi), 32'd0);
    chk("rst_busy", 32'(b_if.busy), 32'd0);
    chk("rst_done", 32'(b_if.done), 32'd0);
    chk("rst_pass", 32'(b_if.pass), 32'd0);
    chk("rst_sig", 32'(b_if.signature), 32'd0);
    chk("rst_idx", 32'(b_if.pat_idx), 32'd0);
    chk("rst_a_sig", 32'(a_if.signature), 32'(AMS));
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk_en = 1'b1;

    chk("pin_lfsr_wrap", 32'(lfsr_step(18'h20000)), 32'h00001);
    chk("pin_lfsr_tap", 32'(lfsr_step(18'h00400)), 32'h00801);
    chk("pin_misr_fold", 32'(misr_step(19'h40000, 19'h00000)), 32'h00027);

    b_if.start = 1'b1; c_if.start = 1'b1; d_if.start = 1'b1;
    @(posedge ck);
    @(negedge ck);
    b_if.start = 1'b0; c_if.start = 1'b0; d_if.start = 1'b0;
    done_at = -1;
    g18_hi  = 0;
    for (int n = 0; n < 10; n++) begin
      if (n >= 2 && n <= 5) chk($sformatf("b_pat%0d", n - 2), 32'(b_if.dut_pi), 32'd1 << (n - 2));
      if (n == 2) chk("c_first_pat", 32'(c_if.dut_pi), 32'h00001);
      if (n == 3) chk("c_cmp_pi", 32'(c_if.dut_pi), 32'd0);
      if (b_if.dut_pi[17]) g18_hi++;
      if (b_if.done && done_at < 0) done_at = n;
      @(negedge ck);
    end
    chk("b_done_latency", 32'(done_at), 32'd7);
    chk("b_g18_cycles", 32'(g18_hi), 32'd2);
    chk("b_sig", 32'(b_if.signature), 32'd0);
    chk("b_idx", 32'(b_if.pat_idx), 32'd4);
    chk("b_busy", 32'(b_if.busy), 32'd0);
    chk("b_pass", 32'(b_if.pass), 32'd1);
    chk("c_sig", 32'(c_if.signature), 32'h00001);
    chk("c_pass", 32'(c_if.pass), 32'd1);
    chk("c_idx", 32'(c_if.pat_idx), 32'd1);
    chk("d_sig", 32'(d_if.signature), 32'h00001);
    chk("d_pass", 32'(d_if.pass), 32'd0);

    b_if.start = 1'b1;
    @(negedge ck);
    b_if.start = 1'b0;
    chk("b_restart_done", 32'(b_if.done), 32'd0);
    chk("b_restart_busy", 32'(b_if.busy), 32'd1);
    chk("b_restart_pi", 32'(b_if.dut_pi), 32'(CLRM));
    chk("b_restart_pass", 32'(b_if.pass), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      a_if.dut_po = 19'($urandom);
      a_if.start  = ($urandom_range(0, 11) == 0);
      rst_a       = ($urandom_range(0, 299) == 0);
      @(negedge ck);
    end

    rst_a = 1'b1; a_if.start = 1'b0;
    @(negedge ck);
    rst_a = 1'b0; a_if.start = 1'b1;
    @(negedge ck);
    a_if.start = 1'b0;
    for (int k = 0; k < 60 && a_if.pat_idx != 16'd5; k++) @(negedge ck);
    chk("t5_reach5", 32'(a_if.pat_idx), 32'd5);
    a_if.start = 1'b1;
    @(negedge ck);
    a_if.start = 1'b0;
    chk("t5_start_ignored", 32'(a_if.pat_idx), 32'd6);
    for (int k = 0; k < 60 && a_if.pat_idx != 16'd10; k++) @(negedge ck);
    chk("t5_reach10", 32'(a_if.pat_idx), 32'd10);
    rst_a = 1'b1;
    @(negedge ck);
    chk("t5_abort_idx", 32'(a_if.pat_idx), 32'd0);
    chk("t5_abort_busy", 32'(a_if.busy), 32'd0);
    chk("t5_abort_pi", 32'(a_if.dut_pi), 32'd0);
    rst_a = 1'b0;
    @(negedge ck);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
